// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - MIPS ALU with branch-target adder and iterative mul/div unit (HI/LO)
module alu_muldiv #(
  parameter int WIDTH    = 32,
  parameter int PC_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [WIDTH-1:0] pc,
  input  logic [3:0]       sel,
  input  logic             md_start,
  input  logic             md_signed,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_flag,
  output logic [WIDTH-1:0] add_result,
  output logic             busy,
  output logic             md_done,
  output logic             div_by_zero,
  output logic             stall
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MFHI = 4'd11;
  localparam logic [3:0] OP_MFLO = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_DIV  = 4'd14;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   m_op;
  logic [WIDTH-1:0]   p_hi, p_lo;
  logic               op_div, sgn, neg_q, neg_r;
  logic [SW-1:0]      cnt;

  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign shamt      = a[SW-1:0];
  assign zero_flag  = (a == b);
  assign add_result = (imm_ext << PC_SHIFT) + pc;
  assign stall      = busy & (sel == OP_MFHI || sel == OP_MFLO || sel == OP_MUL || sel == OP_DIV);

  always_comb begin
    alu_out = '0;
    case (sel)
      OP_AND:  alu_out = a & b;
      OP_ADD:  alu_out = a + b;
      OP_OR:   alu_out = a | b;
      OP_SUB:  alu_out = a - b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_NOR:  alu_out = ~(a | b);
      OP_XOR:  alu_out = a ^ b;
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  alu_out = b << shamt;
      OP_SRL:  alu_out = b >> shamt;
      OP_SRA:  alu_out = $signed(b) >>> shamt;
      OP_MFHI: alu_out = hi;
      OP_MFLO: alu_out = lo;
      default: alu_out = '0;
    endcase
  end

  // Operands are captured raw at accept; magnitudes are formed one cycle later in PREP.
  assign abs_a     = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b     = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_op} : {(WIDTH+1){1'b0}});
  assign div_trial = {p_hi, p_lo[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, m_op};
  assign prod      = {p_hi, p_lo};
  assign prod_fix  = neg_q ? -prod : prod;
  assign q_fix     = neg_q ? -p_lo : p_lo;
  assign r_fix     = neg_r ? -p_hi : p_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      md_done     <= 1'b0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      m_op        <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      op_div      <= 1'b0;
      sgn         <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      cnt         <= '0;
    end else begin
      md_done     <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start && (sel == OP_MUL || sel == OP_DIV)) begin
            a_q    <= a;
            b_q    <= b;
            sgn    <= md_signed;
            op_div <= (sel == OP_DIV);
            busy   <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          neg_q <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= sgn & a_q[WIDTH-1];
          m_op  <= op_div ? abs_b : abs_a;
          p_lo  <= op_div ? abs_a : abs_b;
          p_hi  <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (op_div) begin
            // Restoring step: remainder in p_hi, dividend shifts out of p_lo as quotient shifts in.
            if (!div_diff[WIDTH]) begin
              p_hi <= div_diff[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= div_trial[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (&cnt) state <= FIX;
        end
        FIX: begin
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (b_q == '0) begin
            hi          <= a_q;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          md_done <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
